// File: rtl/dict_hamming_pkg.sv
// Shared definitions for the dictionary/Hamming compressor and decompressor.
//  - Geometry localparams (chunk size, codebook size, index width, chunks per word).
//  - The codebook table, shared with the compressor so both ends agree.
//  - FSM state enum for the serial decompressor.
//  - lookup(): index -> codeword; out-of-range indices return all zeros.
//  - quantise()/quantise_word(): nearest-codeword encoder (lowest index wins ties),
//    i.e. what the upstream compressor produces for a raw bitstream.
package dict_hamming_pkg;

    localparam int CHUNK_SIZE     = 4;
    localparam int CODEBOOK_SIZE  = 8;
    localparam int INDEX_BITS     = $clog2(CODEBOOK_SIZE);
    localparam int NUM_CHUNKS     = 4;
    localparam int CHUNK_IDX_BITS = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int BIT_IDX_BITS   = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
    localparam int WORD_BITS      = NUM_CHUNKS * INDEX_BITS;
    localparam int STREAM_BITS    = NUM_CHUNKS * CHUNK_SIZE;

    typedef logic [CHUNK_SIZE-1:0] codeword_t;
    typedef logic [INDEX_BITS-1:0] index_t;

    localparam codeword_t CODEBOOK [CODEBOOK_SIZE] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic codeword_t lookup(input index_t idx);
        codeword_t cw;
        cw = '0;
        if (int'(idx) < CODEBOOK_SIZE) begin
            cw = CODEBOOK[idx];
        end
        return cw;
    endfunction

    function automatic index_t quantise(input codeword_t chunk);
        int best_d;
        int best_i;
        int d;
        best_d = CHUNK_SIZE + 1;
        best_i = 0;
        for (int i = 0; i < CODEBOOK_SIZE; i++) begin
            d = $countones(chunk ^ CODEBOOK[i]);
            if (d < best_d) begin
                best_d = d;
                best_i = i;
            end
        end
        return index_t'(best_i);
    endfunction

    // The stream is written first-bit-leftmost, so chunk 0 is the top CHUNK_SIZE bits.
    function automatic logic [WORD_BITS-1:0] quantise_word(input logic [STREAM_BITS-1:0] bits);
        logic [WORD_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            r[k*INDEX_BITS +: INDEX_BITS] = quantise(bits[(NUM_CHUNKS-1-k)*CHUNK_SIZE +: CHUNK_SIZE]);
        end
        return r;
    endfunction

endpackage

// File: rtl/dict_hamming_codebook_rom.sv
// Combinational codebook lookup.
// Ports:
//  idx      in   INDEX_BITS   codebook index
//  codeword out  CHUNK_SIZE   codeword stored at idx (all zeros if idx is out of range)
module dict_hamming_codebook_rom
    import dict_hamming_pkg::*;
(
    input  logic [INDEX_BITS-1:0] idx,
    output logic [CHUNK_SIZE-1:0] codeword
);

    assign codeword = lookup(idx);

endmodule

// File: rtl/dict_hamming_decompressor_serial.sv
// Serial dictionary decompressor: accepts one packed word of NUM_CHUNKS codebook
// indices, looks each up in the shared codebook and streams the reconstructed
// bits out one per clock (chunk 0 first, each codeword MSB first), with
// valid/ready flow control on the output and a one-cycle done pulse at the end.
// Ports:
//  clk                 in   1          clock, all logic on posedge
//  rst                 in   1          synchronous active-high reset
//  compressed_in       in   WORD_BITS  packed indices, index k at [k*INDEX_BITS +: INDEX_BITS]
//  compressed_valid    in   1          compressed_in valid
//  in_ready            out  1          high in IDLE only
//  data_out            out  1          reconstructed bit
//  data_out_valid      out  1          data_out valid (EMIT)
//  out_ready           in   1          downstream accepts data_out
//  decompression_done  out  1          one-cycle pulse after the last transfer
module dict_hamming_decompressor_serial
    import dict_hamming_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] compressed_in,
    input  logic                 compressed_valid,
    output logic                 in_ready,
    output logic                 data_out,
    output logic                 data_out_valid,
    input  logic                 out_ready,
    output logic                 decompression_done
);

    state_t                    state_reg;
    state_t                    state_next;
    logic [WORD_BITS-1:0]      word_reg;
    logic [CHUNK_IDX_BITS-1:0] chunk_idx_reg;
    logic [BIT_IDX_BITS-1:0]   bit_idx_reg;

    logic [INDEX_BITS-1:0]     idx_arr [NUM_CHUNKS];
    logic [INDEX_BITS-1:0]     cur_idx;
    logic [CHUNK_SIZE-1:0]     codeword;
    logic [CHUNK_SIZE-1:0]     msb_first;

    logic                      accept;
    logic                      transfer;
    logic                      last_bit;
    logic                      last_chunk;

    // Split the latched word into per-chunk indices.
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_idx
        assign idx_arr[gi] = word_reg[gi*INDEX_BITS +: INDEX_BITS];
    end

    assign cur_idx = idx_arr[chunk_idx_reg];

    dict_hamming_codebook_rom u_rom (
        .idx      (cur_idx),
        .codeword (codeword)
    );

    // Bit-reversed copy so that bit_idx 0 selects the codeword MSB.
    for (genvar gi = 0; gi < CHUNK_SIZE; gi++) begin : g_rev
        assign msb_first[gi] = codeword[CHUNK_SIZE-1-gi];
    end

    assign accept     = (state_reg == ST_IDLE) && compressed_valid;
    assign transfer   = (state_reg == ST_EMIT) && out_ready;
    assign last_bit   = (bit_idx_reg   == BIT_IDX_BITS'(CHUNK_SIZE - 1));
    assign last_chunk = (chunk_idx_reg == CHUNK_IDX_BITS'(NUM_CHUNKS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (compressed_valid) state_next = ST_EMIT;
            ST_EMIT: if (transfer && last_bit && last_chunk) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs depend only on registered state and the ROM, never on out_ready.
    always_comb begin
        in_ready           = (state_reg == ST_IDLE);
        data_out_valid     = (state_reg == ST_EMIT);
        decompression_done = (state_reg == ST_DONE);
        data_out           = (state_reg == ST_EMIT) ? msb_first[bit_idx_reg] : 1'b0;
    end

    // Latched word and position counters; counters hold during stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg      <= '0;
            chunk_idx_reg <= '0;
            bit_idx_reg   <= '0;
        end else if (accept) begin
            word_reg      <= compressed_in;
            chunk_idx_reg <= '0;
            bit_idx_reg   <= '0;
        end else if (transfer) begin
            if (last_bit) begin
                bit_idx_reg   <= '0;
                chunk_idx_reg <= last_chunk ? '0 : chunk_idx_reg + 1'b1;
            end else begin
                bit_idx_reg   <= bit_idx_reg + 1'b1;
            end
        end
    end

endmodule
